pcie_tx_injector: RTL and testbench

Source-side transmitter for the PCIe interconnect device. It takes 6-bit words from a host write port and buffers them in a small local FIFO. It drives the device's data_in/push_data_in inputs and honours the device's MAIN_FIFO_pause back-pressure. A 5-state FSM mirrors the device's init/idle/active handshake, and the block counts words delivered.

---
 rtl/pcie_tx_injector.sv | 162 ++++++++++++++++
 tb/tb_pcie_tx_injector.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_injector.sv
// pcie_tx_injector: buffers host words in a small FIFO and pushes them into the
// device data_in port, honouring MAIN_FIFO_pause and tracking sent words.
// Ports: clk, reset (async, active-low), init, wr_en, wr_data, MAIN_FIFO_pause
//   -> data_out, push_out, tx_full, tx_empty, err_overflow, state_out, sent_cnt
// Optional macro TX_STATS_EN adds sent_d0/sent_d1 per-destination counters.
module pcie_tx_injector #(
  parameter int MEM_SIZE  = 4,
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 wr_en,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 MAIN_FIFO_pause,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 push_out,
  output logic                 tx_full,
  output logic                 tx_empty,
  output logic                 err_overflow,
  output logic [2:0]           state_out,
  output logic [CNT_W-1:0]     sent_cnt
`ifdef TX_STATS_EN
  ,
  output logic [CNT_W-1:0]     sent_d0,
  output logic [CNT_W-1:0]     sent_d1
`endif
);

  typedef enum logic [2:0] {
    S_RESET  = 3'b000,
    S_INIT   = 3'b001,
    S_IDLE   = 3'b010,
    S_ACTIVE = 3'b011,
    S_PAUSE  = 3'b100
  } state_e;

  localparam logic [PTR_L:0] OCC_FULL = (PTR_L+1)'(MEM_SIZE);

  state_e                 state_q, state_d;
  logic [WORD_SIZE-1:0]   mem_q [MEM_SIZE];
  logic [PTR_L-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_L-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_L:0]         occ_q, occ_d;
  logic [WORD_SIZE-1:0]   data_q, data_d;
  logic                   push_q;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       sent_q, sent_d;
  logic [WORD_SIZE-1:0]   head;
  logic                   full, empty;
  logic                   wr_acc, pop;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Write acceptance looks only at the pre-edge fullness, so a same-edge
  // pop never frees a slot for the incoming word.
  assign wr_acc = wr_en & ~full;
  assign pop    = ((state_q == S_IDLE) | (state_q == S_ACTIVE)) &
                  ~init & ~MAIN_FIFO_pause & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    data_d   = data_q;
    err_d    = err_q | (wr_en & full);
    sent_d   = sent_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_L'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_L'(1);
      data_d   = head;
      sent_d   = sent_q + CNT_W'(1);
    end
    if (wr_acc & ~pop)      occ_d = occ_q + (PTR_L+1)'(1);
    else if (pop & ~wr_acc) occ_d = occ_q - (PTR_L+1)'(1);
  end

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = S_INIT;
    end else begin
      unique case (state_q)
        S_RESET: state_d = S_IDLE;
        S_INIT:  state_d = S_IDLE;
        S_IDLE: begin
          if (!empty && !MAIN_FIFO_pause)     state_d = S_ACTIVE;
          else if (!empty && MAIN_FIFO_pause) state_d = S_PAUSE;
        end
        S_ACTIVE: begin
          if (MAIN_FIFO_pause)  state_d = S_PAUSE;
          else if (occ_d == '0) state_d = S_IDLE;
        end
        S_PAUSE: begin
          if (!MAIN_FIFO_pause && !empty)     state_d = S_ACTIVE;
          else if (!MAIN_FIFO_pause && empty) state_d = S_IDLE;
        end
        default: state_d = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RESET;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      data_q   <= '0;
      push_q   <= 1'b0;
      err_q    <= 1'b0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      data_q   <= data_d;
      push_q   <= pop;
      err_q    <= err_d;
      sent_q   <= sent_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
    end else if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef TX_STATS_EN
  logic [CNT_W-1:0] d0_q, d1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d0_q <= '0;
      d1_q <= '0;
    end else if (pop) begin
      if (head[4]) d1_q <= d1_q + CNT_W'(1);
      else         d0_q <= d0_q + CNT_W'(1);
    end
  end

  assign sent_d0 = d0_q;
  assign sent_d1 = d1_q;
`endif

  assign data_out     = data_q;
  assign push_out     = push_q;
  assign tx_full      = full;
  assign tx_empty     = empty;
  assign err_overflow = err_q;
  assign state_out    = state_q;
  assign sent_cnt     = sent_q;

endmodule

// File: tb/tb_pcie_tx_injector.sv
// tb_pcie_tx_injector: directed and random stimulus against a queue-based
// reference model; pushed words are checked by a negedge scoreboard monitor.
module tb_pcie_tx_injector;

  localparam int MS_RESET = 0;
  localparam int MS_INIT  = 1;
  localparam int MS_IDLE  = 2;
  localparam int MS_ACT   = 3;
  localparam int MS_PAUSE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic       wr_en;
  logic [5:0] wr_data;
  logic       MAIN_FIFO_pause;
  logic [5:0] data_out;
  logic       push_out;
  logic       tx_full;
  logic       tx_empty;
  logic       err_overflow;
  logic [2:0] state_out;
  logic [7:0] sent_cnt;
`ifdef TX_STATS_EN
  logic [7:0] sent_d0;
  logic [7:0] sent_d1;
`endif

  pcie_tx_injector dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .MAIN_FIFO_pause (MAIN_FIFO_pause),
    .data_out        (data_out),
    .push_out        (push_out),
    .tx_full         (tx_full),
    .tx_empty        (tx_empty),
    .err_overflow    (err_overflow),
    .state_out       (state_out),
    .sent_cnt        (sent_cnt)
`ifdef TX_STATS_EN
    ,
    .sent_d0         (sent_d0),
    .sent_d1         (sent_d1)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] exp_q[$];
  logic [5:0] m_fifo[$];
  int         m_state;
  logic       m_push;
  logic [5:0] m_data;
  logic       m_err;
  logic [7:0] m_sent;
  logic [7:0] m_d0;
  logic [7:0] m_d1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_state = MS_RESET;
    m_push  = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
    m_sent  = '0;
    m_d0    = '0;
    m_d1    = '0;
  endtask

  task automatic model_edge(input logic w, input logic [5:0] d,
                            input logic p, input logic in);
    bit was_empty;
    bit was_full;
    bit do_pop;
    bit acc;
    logic [5:0] word;
    was_empty = (m_fifo.size() == 0);
    was_full  = (m_fifo.size() == 4);
    do_pop = (m_state == MS_IDLE || m_state == MS_ACT) && !in && !p &&
             !was_empty;
    acc = w && !was_full;
    if (w && was_full) m_err = 1'b1;
    m_push = do_pop;
    if (do_pop) begin
      word = m_fifo.pop_front();
      exp_q.push_back(word);
      m_data = word;
      m_sent = m_sent + 8'd1;
      if (word[4]) m_d1 = m_d1 + 8'd1;
      else         m_d0 = m_d0 + 8'd1;
    end
    if (acc) m_fifo.push_back(d);
    if (in) m_state = MS_INIT;
    else begin
      case (m_state)
        MS_RESET, MS_INIT: m_state = MS_IDLE;
        MS_IDLE:
          if (!was_empty) m_state = p ? MS_PAUSE : MS_ACT;
        MS_ACT:
          if (p) m_state = MS_PAUSE;
          else if (m_fifo.size() == 0) m_state = MS_IDLE;
        MS_PAUSE:
          if (!p) m_state = was_empty ? MS_IDLE : MS_ACT;
        default: m_state = MS_RESET;
      endcase
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state_out), 32'(m_state));
    chk("push", 32'(push_out), 32'(m_push));
    chk("data", 32'(data_out), 32'(m_data));
    chk("full", 32'(tx_full), 32'(m_fifo.size() == 4));
    chk("empty", 32'(tx_empty), 32'(m_fifo.size() == 0));
    chk("err", 32'(err_overflow), 32'(m_err));
    chk("sent", 32'(sent_cnt), 32'(m_sent));
`ifdef TX_STATS_EN
    chk("sent_d0", 32'(sent_d0), 32'(m_d0));
    chk("sent_d1", 32'(sent_d1), 32'(m_d1));
`endif
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic w, input logic [5:0] d,
                      input logic p, input logic in);
    wr_en = w;
    wr_data = d;
    MAIN_FIFO_pause = p;
    init = in;
    model_edge(w, d, p, in);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic in_at_release);
    reset = 1'b0;
    wr_en = 1'b0;
    MAIN_FIFO_pause = 1'b0;
    init = in_at_release;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset && push_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scb_unexpected: got push of %0h expected no push",
                 data_out);
      end else begin
        chk("scb_word", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0;
    init = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    MAIN_FIFO_pause = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset and init handshake
    do_reset(1'b1);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_empty", 32'(tx_empty), 32'd1);
    step(0, 6'h0, 0, 1);
    chk("init_state", 32'(state_out), 32'd1);
    step(0, 6'h0, 0, 0);
    chk("idle_state", 32'(state_out), 32'd2);

    // Single word
    step(1, 6'h15, 0, 0);
    step(0, 6'h0, 0, 0);
    chk("single_push", 32'(push_out), 32'd1);
    chk("single_data", 32'(data_out), 32'h15);
    step(0, 6'h0, 0, 0);
    chk("single_idle", 32'(state_out), 32'd2);
    chk("single_cnt", 32'(sent_cnt), 32'd1);

    // Back-pressure with four buffered words
    do_reset(1'b0);
    step(0, 6'h0, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, 6'(i), 1, 0);
    step(0, 6'h0, 0, 0);
    step(0, 6'h0, 0, 0);
    step(0, 6'h0, 1, 0);
    chk("bp_pause_state", 32'(state_out), 32'd4);
    chk("bp_pause_push", 32'(push_out), 32'd0);
    step(0, 6'h0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 6'h0, 0, 0);
    chk("bp_sent", 32'(sent_cnt), 32'd4);

    // Overflow
    do_reset(1'b0);
    step(0, 6'h0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 6'(8'h20 + i), 1, 0);
    chk("ovf_full", 32'(tx_full), 32'd1);
    chk("ovf_err0", 32'(err_overflow), 32'd0);
    step(1, 6'h3f, 1, 0);
    chk("ovf_err1", 32'(err_overflow), 32'd1);
    for (int i = 0; i < 7; i++) step(0, 6'h0, 0, 0);
    chk("ovf_sent", 32'(sent_cnt), 32'd4);
    chk("ovf_sticky", 32'(err_overflow), 32'd1);

    // Simultaneous write and pop at occupancy 2, then async reset mid-burst
    do_reset(1'b0);
    step(0, 6'h0, 1, 0);
    step(1, 6'h0a, 1, 0);
    step(1, 6'h0b, 1, 0);
    step(0, 6'h0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 6'(8'h10 + i), 0, 0);
    chk("sim_full", 32'(tx_full), 32'd0);
    chk("sim_empty", 32'(tx_empty), 32'd0);
    wr_en = 1'b1;
    wr_data = 6'h2a;
    model_edge(1'b1, 6'h2a, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all();
    #2;
    reset = 1'b0;
    #1;
    chk("async_push", 32'(push_out), 32'd0);
    chk("async_cnt", 32'(sent_cnt), 32'd0);
    chk("async_state", 32'(state_out), 32'd0);
    chk("async_empty", 32'(tx_empty), 32'd1);
    model_reset();
    @(negedge clk);
    do_reset(1'b0);

`ifdef TX_STATS_EN
    do_reset(1'b0);
    step(0, 6'h0, 0, 0);
    step(1, 6'h01, 0, 0);
    step(1, 6'h12, 0, 0);
    step(1, 6'h03, 0, 0);
    step(1, 6'h34, 0, 0);
    step(1, 6'h25, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 6'h0, 0, 0);
    chk("stats_d0", 32'(sent_d0), 32'd3);
    chk("stats_d1", 32'(sent_d1), 32'd2);
    chk("stats_cnt", 32'(sent_cnt), 32'd5);
`endif

    // Random traffic
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 99) < 55), 6'($urandom),
           logic'($urandom_range(0, 99) < 25),
           logic'($urandom_range(0, 99) < 4));
    end
    for (int i = 0; i < 12; i++) step(0, 6'h0, 0, 0);
    chk("scb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
